// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with two combinational read ports, one writeback
// port and a per-register pending (scoreboard) bit.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset (clears data and pending bits)
//   AD1/AD2        read addresses;  RD1/RD2 read data (combinational)
//   AD3/WD3/WE3    writeback address / data / enable
//   ISS_EN/ISS_RD  issue strobe and destination register to mark pending
//   FLUSH          clear every pending bit
//   BUSY1/BUSY2    pending status of AD1/AD2 (combinational)
//   a0             stored value of register DEBUG_REG (never forwarded)
module reg_file_sb #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BYPASS        = 1,
    parameter int unsigned DEBUG_REG     = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] AD1,
    input  logic [ADDRESS_WIDTH-1:0] AD2,
    output logic [DATA_WIDTH-1:0]    RD1,
    output logic [DATA_WIDTH-1:0]    RD2,
    input  logic [ADDRESS_WIDTH-1:0] AD3,
    input  logic [DATA_WIDTH-1:0]    WD3,
    input  logic                     WE3,
    input  logic                     ISS_EN,
    input  logic [ADDRESS_WIDTH-1:0] ISS_RD,
    input  logic                     FLUSH,
    output logic                     BUSY1,
    output logic                     BUSY2,
    output logic [DATA_WIDTH-1:0]    a0
);

    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      pend_q;
    logic [DEPTH-1:0]      pend_d;

    logic wr_en;
    logic iss_ok;
    logic fwd1;
    logic fwd2;

    // Register 0 is hard-wired: it is never written and never marked pending.
    assign wr_en  = WE3 && (AD3 != '0);
    assign iss_ok = ISS_EN && (ISS_RD != '0);

    // Data array: reset clears everything, otherwise a plain writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[AD3] <= WD3;
        end
    end

    // Pending next state: flush dominates; issue is applied after the
    // writeback clear so a same-index issue wins.
    always_comb begin
        pend_d = pend_q;
        if (FLUSH) begin
            pend_d = '0;
        end else begin
            if (wr_en) begin
                pend_d[AD3] = 1'b0;
            end
            if (iss_ok) begin
                pend_d[ISS_RD] = 1'b1;
            end
        end
    end

    // Pending register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // A read is forwarded when the same non-zero register is being written back.
    assign fwd1 = (BYPASS != 0) && WE3 && (AD3 == AD1) && (AD1 != '0);
    assign fwd2 = (BYPASS != 0) && WE3 && (AD3 == AD2) && (AD2 != '0);

    // Read port 1.
    always_comb begin
        RD1   = '0;
        BUSY1 = 1'b0;
        if (AD1 != '0) begin
            RD1   = fwd1 ? WD3 : regs_q[AD1];
            BUSY1 = fwd1 ? 1'b0 : pend_q[AD1];
        end
    end

    // Read port 2.
    always_comb begin
        RD2   = '0;
        BUSY2 = 1'b0;
        if (AD2 != '0) begin
            RD2   = fwd2 ? WD3 : regs_q[AD2];
            BUSY2 = fwd2 ? 1'b0 : pend_q[AD2];
        end
    end

    // Debug view of the stored register, deliberately not forwarded.
    assign a0 = regs_q[ADDRESS_WIDTH'(DEBUG_REG)];

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: one instance with forwarding, one without, both driven
// by the same stimulus. Directed table first, then random traffic against a
// reference model built from arrays.
module tb_reg_file_sb;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned DBG = 10;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ad1, ad2, ad3, iss_rd;
    logic [DW-1:0] wd3;
    logic          we3, iss_en, flush;

    logic [DW-1:0] rd1_b1, rd2_b1, a0_b1, rd1_b0, rd2_b0, a0_b0;
    logic          busy1_b1, busy2_b1, busy1_b0, busy2_b0;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(1), .DEBUG_REG(DBG)) dut_b1 (
        .clk(clk), .rst(rst), .AD1(ad1), .AD2(ad2), .RD1(rd1_b1), .RD2(rd2_b1),
        .AD3(ad3), .WD3(wd3), .WE3(we3), .ISS_EN(iss_en), .ISS_RD(iss_rd),
        .FLUSH(flush), .BUSY1(busy1_b1), .BUSY2(busy2_b1), .a0(a0_b1));

    reg_file_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(0), .DEBUG_REG(DBG)) dut_b0 (
        .clk(clk), .rst(rst), .AD1(ad1), .AD2(ad2), .RD1(rd1_b0), .RD2(rd2_b0),
        .AD3(ad3), .WD3(wd3), .WE3(we3), .ISS_EN(iss_en), .ISS_RD(iss_rd),
        .FLUSH(flush), .BUSY1(busy1_b0), .BUSY2(busy2_b0), .a0(a0_b0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state.
    logic [DW-1:0] m_mem  [NREG];
    bit            m_pend [NREG];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the current inputs to the model as one rising edge would.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we3 && ad3 != 0) m_mem[ad3] = wd3;
            if (flush) begin
                for (int i = 0; i < int'(NREG); i++) m_pend[i] = 1'b0;
            end else begin
                if (we3 && ad3 != 0) m_pend[ad3] = 1'b0;
                if (iss_en && iss_rd != 0) m_pend[iss_rd] = 1'b1;
            end
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we3 && ad3 == a) return wd3;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && we3 && ad3 == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic check_model();
        check("rand_rd1_b1",   rd1_b1,   exp_rd(ad1, 1'b1));
        check("rand_rd2_b1",   rd2_b1,   exp_rd(ad2, 1'b1));
        check("rand_rd1_b0",   rd1_b0,   exp_rd(ad1, 1'b0));
        check("rand_rd2_b0",   rd2_b0,   exp_rd(ad2, 1'b0));
        check("rand_busy1_b1", DW'(busy1_b1), DW'(exp_busy(ad1, 1'b1)));
        check("rand_busy2_b1", DW'(busy2_b1), DW'(exp_busy(ad2, 1'b1)));
        check("rand_busy1_b0", DW'(busy1_b0), DW'(exp_busy(ad1, 1'b0)));
        check("rand_busy2_b0", DW'(busy2_b0), DW'(exp_busy(ad2, 1'b0)));
        check("rand_a0_b1",    a0_b1,    m_mem[DBG]);
        check("rand_a0_b0",    a0_b0,    m_mem[DBG]);
    endtask

    typedef struct {
        logic          rst;
        logic          we;
        logic [AW-1:0] ad3;
        logic [DW-1:0] wd;
        logic          iss;
        logic [AW-1:0] isrd;
        logic          flush;
        logic [AW-1:0] ad1;
        logic [AW-1:0] ad2;
        bit            chk;
        logic [DW-1:0] rd1_b1;
        logic [DW-1:0] rd1_b0;
        logic          busy1;
        logic          busy2_b1;
        logic          busy2_b0;
        logic [DW-1:0] a0;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic r, input logic w, input logic [AW-1:0] a3,
                                input logic [DW-1:0] d, input logic i, input logic [AW-1:0] ir,
                                input logic f, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input bit c, input logic [DW-1:0] e1b1, input logic [DW-1:0] e1b0,
                                input logic eb1, input logic eb2b1, input logic eb2b0,
                                input logic [DW-1:0] ea0);
        vec_t v;
        v.rst = r; v.we = w; v.ad3 = a3; v.wd = d; v.iss = i; v.isrd = ir; v.flush = f;
        v.ad1 = a1; v.ad2 = a2; v.chk = c; v.rd1_b1 = e1b1; v.rd1_b0 = e1b0;
        v.busy1 = eb1; v.busy2_b1 = eb2b1; v.busy2_b0 = eb2b0; v.a0 = ea0;
        return v;
    endfunction

    initial begin
        rst = 1'b1; we3 = 0; ad3 = 0; wd3 = 0; iss_en = 0; iss_rd = 0; flush = 0; ad1 = 0; ad2 = 0;

        //            rst we ad3 wd            iss isrd fl ad1 ad2 chk rd1_b1        rd1_b0        b1 b2b1 b2b0 a0
        vecs.push_back(mk(1, 0, 0,  32'h0,        0, 0,  0, 0,  0,  0, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0,  0,  1, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 5,  32'hDEADBEEF, 0, 0,  0, 5,  0,  1, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 5,  0,  1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0,  32'h1234,     0, 0,  0, 0,  0,  1, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 7,  0, 0,  7,  1, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 0,  7,  1, 32'h0,        32'h0,        0, 1, 1, 32'h0));
        vecs.push_back(mk(0, 1, 7,  32'h77,       0, 0,  0, 0,  7,  1, 32'h0,        32'h0,        0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 7,  7,  1, 32'h77,       32'h77,       0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 3,  32'h33,       1, 3,  0, 3,  3,  1, 32'h33,       32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 3,  3,  1, 32'h33,       32'h33,       1, 1, 1, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 1,  0, 0,  0,  1, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 2,  0, 0,  0,  1, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 10, 0, 2,  1,  1, 32'h0,        32'h0,        1, 1, 1, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        1, 4,  1, 3,  10, 1, 32'h33,       32'h33,       1, 1, 1, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 10, 4,  1, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 2,  1,  1, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 10, 32'h55,       1, 6,  0, 10, 6,  1, 32'h55,       32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 12, 32'hAA,       1, 9,  0, 10, 6,  1, 32'h55,       32'h55,       0, 1, 1, 32'h55));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 10, 6,  1, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 12, 9,  1, 32'h0,        32'h0,        0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        0, 0,  0, 5,  3,  1, 32'h0,        32'h0,        0, 0, 0, 32'h0));

        foreach (vecs[k]) begin
            rst = vecs[k].rst; we3 = vecs[k].we; ad3 = vecs[k].ad3; wd3 = vecs[k].wd;
            iss_en = vecs[k].iss; iss_rd = vecs[k].isrd; flush = vecs[k].flush;
            ad1 = vecs[k].ad1; ad2 = vecs[k].ad2;
            @(negedge clk);
            if (vecs[k].chk) begin
                check($sformatf("v%0d_rd1_b1", k),   rd1_b1,          vecs[k].rd1_b1);
                check($sformatf("v%0d_rd1_b0", k),   rd1_b0,          vecs[k].rd1_b0);
                check($sformatf("v%0d_busy1_b1", k), DW'(busy1_b1),   DW'(vecs[k].busy1));
                check($sformatf("v%0d_busy1_b0", k), DW'(busy1_b0),   DW'(vecs[k].busy1));
                check($sformatf("v%0d_busy2_b1", k), DW'(busy2_b1),   DW'(vecs[k].busy2_b1));
                check($sformatf("v%0d_busy2_b0", k), DW'(busy2_b0),   DW'(vecs[k].busy2_b0));
                check($sformatf("v%0d_a0_b1", k),    a0_b1,           vecs[k].a0);
                check($sformatf("v%0d_a0_b0", k),    a0_b0,           vecs[k].a0);
            end
            @(posedge clk);
            model_edge();
            #1;
        end

        // Random traffic; addresses favour a small window so collisions are common.
        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(0, 40) == 0);
            we3    = $urandom_range(0, 1) == 1;
            iss_en = $urandom_range(0, 2) != 0;
            flush  = ($urandom_range(0, 15) == 0);
            wd3    = $urandom();
            ad3    = $urandom_range(0, 1) == 1 ? AW'($urandom_range(0, 11)) : AW'($urandom());
            iss_rd = AW'($urandom_range(0, 11));
            ad1    = $urandom_range(0, 3) == 0 ? ad3 : AW'($urandom_range(0, 11));
            ad2    = $urandom_range(0, 3) == 0 ? ad1 : AW'($urandom_range(0, 11));
            @(negedge clk);
            check_model();
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL provide parameter ADDRESS_WIDTH, default 5, register index width; depth = 2**ADDRESS_WIDTH.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL provide parameter BYPASS, default 1, write-to-read forwarding enable (0/1).
REQ-004 SHALL provide parameter DEBUG_REG, default 10, index of the register driven on a0.
REQ-005 SHALL provide ports, one per line, as listed below:
  clk  input  1  single clock; all state updates on rising edge.
  rst  input  1  synchronous, active-high reset.
  AD1  input  ADDRESS_WIDTH  read port 1 address.
  AD2  input  ADDRESS_WIDTH  read port 2 address.
  RD1  output  DATA_WIDTH  read port 1 data.
  RD2  output  DATA_WIDTH  read port 2 data.
  AD3  input  ADDRESS_WIDTH  writeback address.
  WD3  input  DATA_WIDTH  writeback data.
  WE3  input  1  writeback enable.
  ISS_EN  input  1  issue strobe: mark ISS_RD pending.
  ISS_RD  input  ADDRESS_WIDTH  destination of issued instruction.
  FLUSH  input  1  clear all pending bits.
  BUSY1  output  1  AD1 has an outstanding write.
  BUSY2  output  1  AD2 has an outstanding write.
  a0  output  DATA_WIDTH  stored value of register DEBUG_REG.

Function
REQ-006 SHALL hold 2**ADDRESS_WIDTH data registers plus one pending bit per register.
REQ-007 SHALL write WD3 to register AD3 at the rising edge when WE3=1, AD3!=0, rst=0.
REQ-008 SHALL keep register 0 at zero: writes to 0 ignored; reads of 0 return 0; pending[0] never set.
REQ-009 SHALL drive RD1/RD2 combinationally from the stored array (zero latency).
REQ-010 SHALL, when BYPASS=1 and WE3=1 and AD3==ADn and ADn!=0, drive RDn=WD3 in the same cycle; when BYPASS=0, RDn shows the old value until the following cycle.
REQ-011 SHALL drive a0 from the stored register DEBUG_REG, never bypassed (updates one cycle after the write).
REQ-012 SHALL set pending[ISS_RD] at the edge when ISS_EN=1, ISS_RD!=0, FLUSH=0, rst=0.
REQ-013 SHALL clear pending[AD3] at the edge when WE3=1 and AD3!=0.
REQ-014 SHALL, when set and clear target the same index in one cycle, leave the bit set (issue wins).
REQ-015 SHALL, when FLUSH=1, clear all pending bits at the edge, ignore ISS_EN that cycle, and still perform any WE3 data write.
REQ-016 SHALL drive BUSYn=pending[ADn], forced 0 for ADn=0, and forced 0 when BYPASS=1 and a matching writeback (WE3=1, AD3==ADn) occurs that cycle.
REQ-017 SHALL serve both read ports independently, including AD1==AD2.
REQ-018 SHALL NOT set pending or write data when rst=1, regardless of other inputs.

Reset
REQ-019 SHALL, at a rising edge with rst=1, clear all data registers and pending bits to 0.
REQ-020 SHALL, the cycle after reset, present RD1=RD2=a0=0 and BUSY1=BUSY2=0 (absent bypass).
REQ-021 SHALL, when rst is asserted mid-operation, discard all outstanding pending state with no partial write.

Verification
REQ-022 SHALL cover: write x5=0xDEADBEEF, next cycle AD1=5 -> RD1=0xDEADBEEF; same-cycle AD1=5 -> RD1=0xDEADBEEF if BYPASS=1, old value if BYPASS=0.
REQ-023 SHALL cover: WE3=1, AD3=0, WD3=0x1234 -> RD1 at AD1=0 stays 0, BUSY1=0.
REQ-024 SHALL cover: issue ISS_RD=7 -> next cycle AD2=7 gives BUSY2=1; writeback AD3=7 -> BUSY2=0 same cycle (BYPASS=1), 0 after edge in both modes.
REQ-025 SHALL cover: ISS_EN with ISS_RD=3 and WE3 with AD3=3 same cycle -> pending[3]=1 after edge, register 3 holds WD3.
REQ-026 SHALL cover: pending set on x1,x2,x10; FLUSH=1 with ISS_EN ISS_RD=4 -> all BUSY=0 after edge, x4 not pending.
REQ-027 SHALL cover: write x10=0x55, rst=1 next edge -> a0=0x55 one cycle after write, a0=0 and all registers 0 after reset edge.
